io_responder: RTL and testbench
===============================

# io_responder

Peripheral-side responder for the core's non-Mano `IOR`/`IOW` instructions. It sits between the control unit's I/O request lines and the outside world.

- `IOR` pops a word from an input FIFO fed by an external producer.
- `IOW` loads an output holding register drained by an external consumer.
- Transfers with the control unit use a 4-phase req/ack handshake, so the CU can stall in its I/O execute state until the responder is ready.

## Interface

Parameters:
- `DW`, 16, data word width (matches core register width).
- `FIFO_DEPTH`, 4, input FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 255, wait limit; used only with `IO_TIMEOUT_EN`.

Ports (one synchronous active-low reset, one clock; everything is sampled on the rising edge of `clk`):
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous reset, active low.
- `io_req` in 1: CU request; held until `io_ack` is seen, then dropped.
- `io_we` in 1: 1 = `IOW`, 0 = `IOR`; stable while `io_req` = 1.
- `io_wdata` in DW: `IOW` data; stable while `io_req` = 1.
- `io_rdata` out DW: `IOR` result; valid while `io_ack` = 1.
- `io_ack` out 1: transfer complete; held until `io_req` = 0.
- `io_err` out 1: timeout completion flag; valid with `io_ack`.
- `ext_in_valid` in 1: external producer has a word.
- `ext_in_data` in DW: producer word.
- `ext_in_ready` out 1: FIFO not full.
- `ext_out_valid` out 1: holding register full.
- `ext_out_data` out DW: holding register contents.
- `ext_out_ready` in 1: consumer accepts the word.

## Operation

States:
- **IDLE**: `io_ack` = 0.
  - `io_req`=1, `io_we`=0:
    - FIFO non-empty → pop head into `io_rdata`, go ACK.
    - FIFO empty → go RD_WAIT.
  - `io_req`=1, `io_we`=1:
    - write slot free → capture `io_wdata` into `ext_out_data`, set `ext_out_valid`, go ACK.
    - otherwise → go WR_WAIT.
- **RD_WAIT**: each cycle, if FIFO non-empty → pop, go ACK.
- **WR_WAIT**: each cycle, if write slot free → capture, go ACK.
- **ACK**: `io_ack` = 1. Go IDLE the cycle after `io_req` = 0 is sampled. `io_req` held high is not a new request.

Write slot and holding register:
- Write slot free = `!ext_out_valid || ext_out_ready`. A drain and a new capture in the same cycle leaves `ext_out_valid` = 1 with the new data.
- `ext_out_valid` clears on `ext_out_valid && ext_out_ready` when there is no capture in that cycle.
- `ext_out_data` is stable while `ext_out_valid` = 1 and the consumer has not accepted.

Input FIFO:
- Push on `ext_in_valid && ext_in_ready`.
- `ext_in_ready` = !full, computed from the registered count only; a pop in the same cycle does not open a slot.
- Push and pop in the same cycle (not full, not empty): count unchanged.
- A word pushed into an empty FIFO is poppable from the next cycle.
- Read and write pointers wrap modulo `FIFO_DEPTH`. The count register is log2(`FIFO_DEPTH`)+1 bits.

`io_rdata` holds its last value outside ACK. It is registered, not combinational from the FIFO.

Reset (`rst_n` = 0 at an edge, any state, including mid-wait or mid-ACK):
- state → IDLE.
- FIFO emptied (pointers and count = 0).
- `io_ack`, `io_err`, `ext_out_valid` = 0; `io_rdata`, `ext_out_data` = 0.
- `ext_in_ready` = 1 from the first cycle after reset.

## Timing

- Edge *n* samples `io_req`=1 in IDLE with the resource ready → `io_ack` = 1 from cycle *n*+1.
  - For a read, `io_rdata` is valid from *n*+1.
  - For a write, `ext_out_valid` = 1 and `ext_out_data` = `io_wdata` from *n*+1.
- Wait states: the resource becomes ready at edge *m* → `io_ack` from *m*+1.
- Release: `io_req`=0 sampled at edge *k* in ACK → `io_ack` = 0 from *k*+1. The earliest next request is sampled at *k*+1.
- Minimum round trip: 3 cycles (req, ack, release).

## Configuration

`IO_TIMEOUT_EN`:
- **Defined**: a wait counter runs in RD_WAIT/WR_WAIT and clears on entry to IDLE.
  - Counter width: enough to hold `TIMEOUT_CYCLES`.
  - On reaching `TIMEOUT_CYCLES` wait cycles the block goes to ACK with `io_err` = 1.
  - Timed-out read: `io_rdata` = 0, no pop. Timed-out write: no capture.
  - `io_err` clears when leaving ACK.
- **Undefined**: no counter; waits last indefinitely; `io_err` tied 0.

## Test plan

- **Reset mid-read-wait**: issue `IOR` with the FIFO empty, assert `rst_n`=0 for one edge → state IDLE, `io_ack`=0, `ext_in_ready`=1, `io_rdata`=0x0000.
- **Back-to-back reads**: push 0x1234 and 0xABCD, then issue `IOR` twice → `io_rdata` 0x1234 then 0xABCD; each ack rises 1 cycle after the req is sampled; FIFO ends empty.
- **Read stall**: `IOR` with FIFO empty, push 0x00FF 5 cycles later → `io_ack` rises 2 cycles after the push edge with `io_rdata`=0x00FF.
- **Full FIFO / write stall**:
  - Fill 4 entries → `ext_in_ready`=0; a 5th push (0x5555) is not accepted even in a pop cycle.
  - Then `IOW` 0x0001 and `IOW` 0x0002 with `ext_out_ready`=0 → the second write waits; set `ext_out_ready`=1 → ack 1 cycle later, `ext_out_data`=0x0002.
- **Handshake hold**: keep `io_req`=1 for 4 cycles after ack → `io_ack` stays 1 and no second pop occurs.
- **Timeout (with `IO_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8)**: `IOR` with FIFO empty → `io_ack`=1, `io_err`=1, `io_rdata`=0 after 8 wait cycles. Without the macro, no ack within 100 cycles.

Source files
------------

// File: rtl/io_responder.sv
// io_responder: peripheral-side responder for the core's IOR/IOW instructions.
// IOR pops the input FIFO, IOW loads the output holding register; both are
// acknowledged to the control unit with a 4-phase req/ack handshake.
// Optional build macro IO_TIMEOUT_EN: bounds RD_WAIT/WR_WAIT to TIMEOUT_CYCLES
// wait cycles and completes a timed-out transfer with io_err = 1.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no transfer in progress, io_ack = 0
// S_RD_WAIT | IOR pending, input FIFO empty
// S_WR_WAIT | IOW pending, holding register occupied and not draining
// S_ACK     | transfer done, io_ack = 1 until io_req is released
module io_responder #(
    parameter int DW             = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [DW-1:0] io_wdata,
    output logic [DW-1:0] io_rdata,
    output logic          io_ack,
    output logic          io_err,
    input  logic          ext_in_valid,
    input  logic [DW-1:0] ext_in_data,
    output logic          ext_in_ready,
    output logic          ext_out_valid,
    output logic [DW-1:0] ext_out_data,
    input  logic          ext_out_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty, fifo_full;
    logic          push, do_pop, do_cap;
    logic          wr_free;
    logic          timeout;

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == CW'(FIFO_DEPTH));
    // Full is judged from the registered count only, so a same-cycle pop
    // never opens a slot for the producer.
    assign ext_in_ready = !fifo_full;
    assign push         = ext_in_valid && !fifo_full;
    // A draining holding register can accept a new word in the same cycle.
    assign wr_free      = !ext_out_valid || ext_out_ready;

`ifdef IO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] WAIT_TC = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wait_cnt;

    // Counts cycles spent waiting; anything outside a wait state clears it,
    // so every wait starts from zero after passing through IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_RD_WAIT || state == S_WR_WAIT) begin
            wait_cnt <= wait_cnt + TW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout = (state == S_RD_WAIT || state == S_WR_WAIT) && (wait_cnt == WAIT_TC);

    // Error flag marks a completion caused by timeout; cleared on release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io_err <= 1'b0;
        end else if (state == S_ACK && !io_req) begin
            io_err <= 1'b0;
        end else if (timeout && !do_pop && !do_cap) begin
            io_err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign io_err  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a ready resource wins over a coincident timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (io_req) begin
                    if (!io_we) begin
                        state_nxt = fifo_empty ? S_RD_WAIT : S_ACK;
                    end else begin
                        state_nxt = wr_free ? S_ACK : S_WR_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                if (!fifo_empty || timeout) begin
                    state_nxt = S_ACK;
                end
            end
            S_WR_WAIT: begin
                if (wr_free || timeout) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (!io_req) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs and datapath strobes decoded from the current state.
    always_comb begin
        io_ack = (state == S_ACK);
        do_pop = 1'b0;
        do_cap = 1'b0;
        case (state)
            S_IDLE: begin
                if (io_req) begin
                    do_pop = !io_we && !fifo_empty;
                    do_cap = io_we && wr_free;
                end
            end
            S_RD_WAIT: do_pop = !fifo_empty;
            S_WR_WAIT: do_cap = wr_free;
            default: begin
                do_pop = 1'b0;
                do_cap = 1'b0;
            end
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ext_in_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Read result register: loaded on pop, zeroed by a read timeout, else held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io_rdata <= '0;
        end else if (do_pop) begin
            io_rdata <= mem[rd_ptr];
        end else if (state == S_RD_WAIT && timeout) begin
            io_rdata <= '0;
        end
    end

    // Output holding register; a capture takes priority over a drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext_out_valid <= 1'b0;
            ext_out_data  <= '0;
        end else if (do_cap) begin
            ext_out_valid <= 1'b1;
            ext_out_data  <= io_wdata;
        end else if (ext_out_ready) begin
            ext_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// Testbench for io_responder: a per-cycle vector table for the directed
// corner cases, hand-written wait/timeout sequences, then randomized
// handshake traffic checked against a transaction-level reference model.
module tb_io_responder;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          io_req = 1'b0;
    logic          io_we = 1'b0;
    logic [DW-1:0] io_wdata = '0;
    logic [DW-1:0] io_rdata;
    logic          io_ack;
    logic          io_err;
    logic          ext_in_valid = 1'b0;
    logic [DW-1:0] ext_in_data = '0;
    logic          ext_in_ready;
    logic          ext_out_valid;
    logic [DW-1:0] ext_out_data;
    logic          ext_out_ready = 1'b0;

    io_responder #(
        .DW(DW),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io_req(io_req),
        .io_we(io_we),
        .io_wdata(io_wdata),
        .io_rdata(io_rdata),
        .io_ack(io_ack),
        .io_err(io_err),
        .ext_in_valid(ext_in_valid),
        .ext_in_data(ext_in_data),
        .ext_in_ready(ext_in_ready),
        .ext_out_valid(ext_out_valid),
        .ext_out_data(ext_out_data),
        .ext_out_ready(ext_out_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        req;
        logic        we;
        logic [15:0] wd;
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic        ack;
        logic [15:0] rd;
        logic        ir;
        logic        ov;
        logic [15:0] od;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic q, logic w, logic [15:0] wd, logic iv,
                                logic [15:0] id, logic o, logic a, logic [15:0] rd,
                                logic ir, logic ov, logic [15:0] od);
        vec_t v;
        v = '{rst: r, req: q, we: w, wd: wd, iv: iv, id: id, ordy: o,
              ack: a, rd: rd, ir: ir, ov: ov, od: od};
        return v;
    endfunction

    task automatic do_read(input string nm, input logic [15:0] exp);
        io_req = 1'b1;
        io_we  = 1'b0;
        tick();
        chk({nm, "_ack"}, io_ack, 1);
        chk({nm, "_rdata"}, io_rdata, exp);
        io_req = 1'b0;
        tick();
        chk({nm, "_release"}, io_ack, 0);
    endtask

    // reference model state for the random phase
    logic [15:0] q[$];
    logic        m_ack, m_err, m_ov;
    logic [15:0] m_rd, m_od;
    int          nr;

    initial begin
        // rows: rst req we wdata iv idata ordy | ack rdata in_ready out_valid out_data
        vecs.push_back(mk(0,0,0,16'h0,0,16'h0,0, 0,16'h0,1,0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,0,16'h0,0, 0,16'h0,1,0,16'h0));
        // read into an empty FIFO, then reset in the middle of the wait
        vecs.push_back(mk(1,1,0,16'h0,0,16'h0,0, 0,16'h0,1,0,16'h0));
        vecs.push_back(mk(1,1,0,16'h0,0,16'h0,0, 0,16'h0,1,0,16'h0));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0,0, 0,16'h0,1,0,16'h0));
        vecs.push_back(mk(1,0,0,16'h0,0,16'h0,0, 0,16'h0,1,0,16'h0));
        // back-to-back reads
        vecs.push_back(mk(1,0,0,16'h0,1,16'h1234,0, 0,16'h0,1,0,16'h0));
        vecs.push_back(mk(1,0,0,16'h0,1,16'hABCD,0, 0,16'h0,1,0,16'h0));
        vecs.push_back(mk(1,1,0,16'h0,0,16'h0,0, 1,16'h1234,1,0,16'h0));
        vecs.push_back(mk(1,0,0,16'h0,0,16'h0,0, 0,16'h1234,1,0,16'h0));
        vecs.push_back(mk(1,1,0,16'h0,0,16'h0,0, 1,16'hABCD,1,0,16'h0));
        vecs.push_back(mk(1,0,0,16'h0,0,16'h0,0, 0,16'hABCD,1,0,16'h0));
        // read stall: push arrives 5 cycles after the request edge
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1,1,0,16'h0,0,16'h0,0, 0,16'hABCD,1,0,16'h0));
        vecs.push_back(mk(1,1,0,16'h0,1,16'h00FF,0, 0,16'hABCD,1,0,16'h0));
        // pop of 00FF coincides with a push of 0BAD; then req held for 4 cycles
        vecs.push_back(mk(1,1,0,16'h0,1,16'h0BAD,0, 1,16'h00FF,1,0,16'h0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1,1,0,16'h0,0,16'h0,0, 1,16'h00FF,1,0,16'h0));
        vecs.push_back(mk(1,0,0,16'h0,0,16'h0,0, 0,16'h00FF,1,0,16'h0));
        // fill to 4 entries
        vecs.push_back(mk(1,0,0,16'h0,1,16'h1111,0, 0,16'h00FF,1,0,16'h0));
        vecs.push_back(mk(1,0,0,16'h0,1,16'h2222,0, 0,16'h00FF,1,0,16'h0));
        vecs.push_back(mk(1,0,0,16'h0,1,16'h3333,0, 0,16'h00FF,0,0,16'h0));
        // 5th push offered in a pop cycle: refused
        vecs.push_back(mk(1,1,0,16'h0,1,16'h5555,0, 1,16'h0BAD,1,0,16'h0));
        vecs.push_back(mk(1,0,0,16'h0,0,16'h0,0, 0,16'h0BAD,1,0,16'h0));
        // writes with the consumer stalled
        vecs.push_back(mk(1,1,1,16'h0001,0,16'h0,0, 1,16'h0BAD,1,1,16'h0001));
        vecs.push_back(mk(1,0,1,16'h0001,0,16'h0,0, 0,16'h0BAD,1,1,16'h0001));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1,1,1,16'h0002,0,16'h0,0, 0,16'h0BAD,1,1,16'h0001));
        vecs.push_back(mk(1,1,1,16'h0002,0,16'h0,1, 1,16'h0BAD,1,1,16'h0002));
        vecs.push_back(mk(1,0,1,16'h0002,0,16'h0,0, 0,16'h0BAD,1,1,16'h0002));
        vecs.push_back(mk(1,0,1,16'h0002,0,16'h0,1, 0,16'h0BAD,1,0,16'h0));
        vecs.push_back(mk(1,0,1,16'h0002,0,16'h0,0, 0,16'h0BAD,1,0,16'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n         = vecs[i].rst;
            io_req        = vecs[i].req;
            io_we         = vecs[i].we;
            io_wdata      = vecs[i].wd;
            ext_in_valid  = vecs[i].iv;
            ext_in_data   = vecs[i].id;
            ext_out_ready = vecs[i].ordy;
            tick();
            chk($sformatf("vec%0d_ack", i), io_ack, vecs[i].ack);
            chk($sformatf("vec%0d_rdata", i), io_rdata, vecs[i].rd);
            chk($sformatf("vec%0d_in_ready", i), ext_in_ready, vecs[i].ir);
            chk($sformatf("vec%0d_out_valid", i), ext_out_valid, vecs[i].ov);
            if (vecs[i].ov)
                chk($sformatf("vec%0d_out_data", i), ext_out_data, vecs[i].od);
            chk($sformatf("vec%0d_err", i), io_err, 0);
        end
        io_we         = 1'b0;
        ext_in_valid  = 1'b0;
        ext_out_ready = 1'b0;

        // drain: the refused 0x5555 must not appear
        do_read("drain0", 16'h1111);
        do_read("drain1", 16'h2222);
        do_read("drain2", 16'h3333);

        // read on the now-empty FIFO
        io_req = 1'b1;
        io_we  = 1'b0;
        tick();
`ifdef IO_TIMEOUT_EN
        begin
            int early = 0;
            for (int i = 0; i < TO - 1; i++) begin
                tick();
                if (io_ack) early++;
            end
            chk("timeout_early_ack", early, 0);
            tick();
            chk("timeout_ack", io_ack, 1);
            chk("timeout_err", io_err, 1);
            chk("timeout_rdata", io_rdata, 0);
            io_req = 1'b0;
            tick();
            chk("timeout_release_ack", io_ack, 0);
            chk("timeout_release_err", io_err, 0);
        end
`else
        begin
            int n_ack = 0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (io_ack) n_ack++;
            end
            chk("no_timeout_ack", n_ack, 0);
            chk("no_timeout_err", io_err, 0);
            ext_in_valid = 1'b1;
            ext_in_data  = 16'h7777;
            tick();
            ext_in_valid = 1'b0;
            chk("late_push_no_ack", io_ack, 0);
            tick();
            chk("late_push_ack", io_ack, 1);
            chk("late_push_rdata", io_rdata, 16'h7777);
            io_req = 1'b0;
            tick();
            chk("late_push_release", io_ack, 0);
        end
`endif

        // randomized traffic against the reference model
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        q.delete();
        m_ack = 0; m_err = 0; m_ov = 0; m_rd = '0; m_od = '0; nr = 0;
        for (int c = 0; c < 3000; c++) begin
            logic push, cap, rdy;
            ext_in_valid  = ($urandom_range(0, 2) == 0);
            ext_in_data   = 16'($urandom);
            ext_out_ready = ($urandom_range(0, 2) == 0);
            if (!io_req && !m_ack) begin
                if ($urandom_range(0, 1) == 1) begin
                    io_req   = 1'b1;
                    io_we    = 1'($urandom_range(0, 1));
                    io_wdata = 16'($urandom);
                    nr       = 0;
                end
            end else if (io_req && m_ack) begin
                if ($urandom_range(0, 2) != 0) io_req = 1'b0;
            end

            push = ext_in_valid && (q.size() < DEPTH);
            cap  = 1'b0;
            if (io_req && !m_ack) begin
                rdy = io_we ? (!m_ov || ext_out_ready) : (q.size() != 0);
                if (rdy) begin
                    m_ack = 1'b1;
                    m_err = 1'b0;
                    if (!io_we) m_rd = q.pop_front();
                    else cap = 1'b1;
                end
`ifdef IO_TIMEOUT_EN
                else if (nr == TO) begin
                    m_ack = 1'b1;
                    m_err = 1'b1;
                    if (!io_we) m_rd = '0;
                end
`endif
                else begin
                    nr++;
                end
            end else if (m_ack && !io_req) begin
                m_ack = 1'b0;
                m_err = 1'b0;
            end
            if (cap) begin
                m_ov = 1'b1;
                m_od = io_wdata;
            end else if (m_ov && ext_out_ready) begin
                m_ov = 1'b0;
            end
            if (push) q.push_back(ext_in_data);

            tick();
            chk("rand_ack", io_ack, m_ack);
            chk("rand_err", io_err, m_err);
            chk("rand_rdata", io_rdata, m_rd);
            chk("rand_in_ready", ext_in_ready, (q.size() < DEPTH));
            chk("rand_out_valid", ext_out_valid, m_ov);
            if (m_ov) chk("rand_out_data", ext_out_data, m_od);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
